// File: rtl/timer_regs_pkg.sv
// Register map, bit positions, response codes and channel states for the timer AXI4-Lite slave.
package timer_regs_pkg;

    localparam int unsigned REG_W = 32;
    localparam int unsigned STRB_W = REG_W / 8;

    // Register word index, taken from address bits [3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 2;
    localparam int unsigned STATUS_EXPIRED_BIT   = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ACCEPT,
        CH_RESP
    } chan_state_t;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Byte-lane merge of new data into an existing register value
    function automatic logic [REG_W-1:0] apply_strb(
        input logic [REG_W-1:0]  old_val,
        input logic [REG_W-1:0]  new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [REG_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock down to a one-cycle tick every PRESCALE_DIV enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == CNT_LAST);

    // Count 0..PRESCALE_DIV-1 while enabled, hold when disabled, restart on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_axi_lite_slave.sv
// AXI4-Lite register slave for the timer: CTRL/LOAD/COUNT/STATUS, prescaled down-counter, level irq.
module timer_axi_lite_slave
    import timer_regs_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned PRESCALE_DIV       = 100
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              irq
);

    chan_state_t wr_state, wr_state_next;
    chan_state_t rd_state, rd_state_next;

    ctrl_t            ctrl;
    logic [REG_W-1:0] load;
    logic [REG_W-1:0] count;
    logic             expired;

    logic [1:0]       wr_idx;
    logic [1:0]       rd_idx;
    logic             wr_fire_c;
    logic             rd_fire_c;
    logic             load_wr_c;
    logic             ctrl_wr_c;
    logic             status_clr_c;
    logic             tick_c;
    logic             expire_c;
    logic [REG_W-1:0] load_next_c;
    logic [REG_W-1:0] rd_mux_c;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx       = S_AXI_AWADDR[3:2];
    assign rd_idx       = S_AXI_ARADDR[3:2];
    assign wr_fire_c    = (wr_state == CH_ACCEPT) && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire_c    = (rd_state == CH_ACCEPT) && S_AXI_ARVALID;
    assign load_wr_c    = wr_fire_c && (wr_idx == REG_LOAD);
    assign ctrl_wr_c    = wr_fire_c && (wr_idx == REG_CTRL) && S_AXI_WSTRB[0];
    assign status_clr_c = wr_fire_c && (wr_idx == REG_STATUS) && S_AXI_WSTRB[0]
                          && S_AXI_WDATA[STATUS_EXPIRED_BIT];
    assign load_next_c  = apply_strb(load, S_AXI_WDATA, S_AXI_WSTRB);
    assign expire_c     = tick_c && (count == '0);

    timer_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .en     (ctrl.en),
        .clear  (load_wr_c),
        .tick_c (tick_c)
    );

    // Write channel next state: idle -> one-cycle accept -> hold response until BREADY
    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            CH_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_next = CH_ACCEPT;
            CH_ACCEPT: wr_state_next = (S_AXI_AWVALID && S_AXI_WVALID) ? CH_RESP : CH_IDLE;
            CH_RESP:   if (S_AXI_BREADY) wr_state_next = CH_IDLE;
            default:   wr_state_next = CH_IDLE;
        endcase
    end

    // Write channel state and registered handshake outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state      <= CH_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            wr_state      <= wr_state_next;
            S_AXI_AWREADY <= (wr_state_next == CH_ACCEPT);
            S_AXI_WREADY  <= (wr_state_next == CH_ACCEPT);
            S_AXI_BVALID  <= (wr_state_next == CH_RESP);
            S_AXI_BRESP   <= RESP_OKAY;
        end
    end

    // Read channel next state: idle -> one-cycle accept -> hold data until RREADY
    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            CH_IDLE:   if (S_AXI_ARVALID) rd_state_next = CH_ACCEPT;
            CH_ACCEPT: rd_state_next = S_AXI_ARVALID ? CH_RESP : CH_IDLE;
            CH_RESP:   if (S_AXI_RREADY) rd_state_next = CH_IDLE;
            default:   rd_state_next = CH_IDLE;
        endcase
    end

    // Read data mux; unused CTRL/STATUS bits read as zero
    always_comb begin
        rd_mux_c = '0;
        case (rd_idx)
            REG_CTRL: begin
                rd_mux_c[CTRL_EN_BIT]          = ctrl.en;
                rd_mux_c[CTRL_AUTO_RELOAD_BIT] = ctrl.auto_reload;
                rd_mux_c[CTRL_IRQ_EN_BIT]      = ctrl.irq_en;
            end
            REG_LOAD:   rd_mux_c = load;
            REG_COUNT:  rd_mux_c = count;
            REG_STATUS: rd_mux_c[STATUS_EXPIRED_BIT] = expired;
            default:    rd_mux_c = '0;
        endcase
    end

    // Read channel state, captured read data and registered handshake outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state      <= CH_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            rd_state      <= rd_state_next;
            S_AXI_ARREADY <= (rd_state_next == CH_ACCEPT);
            S_AXI_RVALID  <= (rd_state_next == CH_RESP);
            S_AXI_RRESP   <= RESP_OKAY;
            if (rd_fire_c) begin
                S_AXI_RDATA <= rd_mux_c;
            end
        end
    end

    // CTRL: software write wins over the one-shot EN auto-clear at expiry
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl <= '0;
        end else if (ctrl_wr_c) begin
            ctrl.en          <= S_AXI_WDATA[CTRL_EN_BIT];
            ctrl.auto_reload <= S_AXI_WDATA[CTRL_AUTO_RELOAD_BIT];
            ctrl.irq_en      <= S_AXI_WDATA[CTRL_IRQ_EN_BIT];
        end else if (expire_c && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    // LOAD/COUNT: a LOAD write reloads COUNT and wins over the tick; COUNT saturates at zero
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            load  <= '0;
            count <= '0;
        end else if (load_wr_c) begin
            load  <= load_next_c;
            count <= load_next_c;
        end else if (tick_c) begin
            if (count != '0) begin
                count <= count - REG_W'(1);
            end else if (ctrl.auto_reload) begin
                count <= load;
            end
        end
    end

    // STATUS.EXPIRED: expiry set wins over a same-cycle write-1-to-clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            expired <= 1'b0;
        end else if (expire_c) begin
            expired <= 1'b1;
        end else if (status_clr_c) begin
            expired <= 1'b0;
        end
    end

    // Level interrupt, one cycle behind the register state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= expired && ctrl.irq_en;
        end
    end

endmodule

// File: tb/tb_timer_axi_lite_slave.sv
// Directed self-checking bench for timer_axi_lite_slave with a 4-cycle prescaler.
module tb_timer_axi_lite_slave;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    timer_axi_lite_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .PRESCALE_DIV       (DIV)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // Rising-edge index, read #1 after an edge or at the following negedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // COUNT after d edges past the enable edge, LOAD=3 one-shot
    function automatic logic [31:0] exp_count(input int d);
        int steps;
        steps = d / int'(DIV);
        return (steps < 3) ? 32'(3 - steps) : 32'd0;
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output int hs);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("wr_accept", 32'({awready, wready}), 32'h3);
        @(posedge clk);
        #1;
        hs = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        resp = bresp;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output int hs);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        hs = cyc;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        data = rvalid ? rdata : 32'hDEAD_DEAD;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          h, e, n;
        logic        stable;

        // Reset values
        #50;
        check_eq("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid, irq}), 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_resp", 32'({bresp, rresp}), 32'h0);
        #50;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), d, h);
            check_eq($sformatf("rst_reg%0d", a), d, 32'h0);
        end

        // LOAD write, COUNT copy, byte strobes
        axi_write(4'h4, 32'h5, 4'hF, r, h);
        check_eq("load_bresp", 32'(r), 32'h0);
        axi_read(4'h4, d, h); check_eq("load_rd", d, 32'h5);
        axi_read(4'h8, d, h); check_eq("count_copy", d, 32'h5);
        axi_write(4'h4, 32'h0000_FFFF, 4'b0001, r, h);
        axi_read(4'h4, d, h); check_eq("load_strb", d, 32'hFF);
        axi_read(4'h8, d, h); check_eq("count_strb", d, 32'hFF);

        // One-shot countdown with exact tick timing
        axi_write(4'h4, 32'h3, 4'hF, r, h);
        axi_write(4'h0, 32'h1, 4'hF, r, e);
        for (int i = 0; i < 7; i++) begin
            axi_read(4'h8, d, h);
            check_eq($sformatf("count_poll%0d", i), d, exp_count(h - 1 - e));
        end
        axi_read(4'hC, d, h); check_eq("oneshot_expired", d, 32'h1);
        axi_read(4'h0, d, h); check_eq("oneshot_en_clr", d, 32'h0);
        check_eq("oneshot_no_irq", 32'(irq), 32'h0);

        // Auto-reload with interrupt
        axi_write(4'hC, 32'h1, 4'hF, r, h);
        axi_write(4'h4, 32'h2, 4'hF, r, h);
        axi_write(4'h0, 32'h7, 4'hF, r, e);
        n = 0;
        while (!irq && n < 60) begin
            n++;
            @(negedge clk);
        end
        check_eq("irq_rise_cycle", 32'(cyc - e), 32'd13);
        axi_read(4'h8, d, h); check_eq("reload_count", d, 32'h2);
        axi_read(4'h0, d, h); check_eq("ctrl_rd", d, 32'h7);
        axi_write(4'hC, 32'h1, 4'hF, r, h);
        check_eq("irq_fall", 32'(irq), 32'h0);
        axi_write(4'h0, 32'h0, 4'hF, r, h);
        axi_write(4'hC, 32'h1, 4'hF, r, h);
        axi_read(4'hC, d, h); check_eq("status_cleared", d, 32'h0);

        // W1C landing on the exact expiry edge loses to the set
        axi_write(4'h4, 32'h1, 4'hF, r, h);
        axi_write(4'h0, 32'h1, 4'hF, r, e);
        while (cyc < e + 6) begin
            @(posedge clk); #1;
        end
        axi_write(4'hC, 32'h1, 4'hF, r, h);
        check_eq("w1c_align", 32'(h - e), 32'd8);
        axi_read(4'hC, d, h); check_eq("w1c_vs_expiry", d, 32'h1);
        axi_write(4'hC, 32'h1, 4'hF, r, h);

        // COUNT is read-only
        axi_write(4'h4, 32'h7, 4'hF, r, h);
        axi_write(4'h8, 32'h99, 4'hF, r, h);
        check_eq("count_wr_bresp", 32'(r), 32'h0);
        axi_read(4'h8, d, h); check_eq("count_ro", d, 32'h7);

        // Back-pressure on B: response held, no second accept
        awaddr = 4'h4; wdata = 32'h1234; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!awready && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        wdata = 32'hBEEF;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bvalid || awready || wready || bresp != 2'b00) stable = 1'b0;
        end
        check_eq("b_hold", 32'(stable), 32'h1);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        check_eq("b_release", 32'(bvalid), 32'h0);
        axi_read(4'h4, d, h); check_eq("b_hold_data", d, 32'h1234);

        // Back-pressure on R: data held, no second accept
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        @(posedge clk); #1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rvalid || arready || rdata != 32'h1234) stable = 1'b0;
        end
        check_eq("r_hold", 32'(stable), 32'h1);
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        check_eq("r_release", 32'(rvalid), 32'h0);

        // Reset in the middle of a read handshake
        araddr = 4'h4; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 50) begin n++; @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outputs", 32'({arready, rvalid, awready, bvalid, irq}), 32'h0);
        arvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(4'h4, d, h); check_eq("rst_mid_load", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
